// File: rtl/result_pkg.sv
// Shared types for the result history logger.
// Entries pack the mux select with the 3-bit result.
package result_pkg;

  localparam int ENTRY_W = 4;

  typedef struct packed {
    logic       sel;
    logic [2:0] val;
  } entry_t;

  localparam logic SEL_DICE    = 1'b0;
  localparam logic SEL_TRAFFIC = 1'b1;

endpackage

// File: rtl/result_history_if.sv
// Read port of the result history FIFO.
// The logger is master; the consumer is slave.
interface result_history_if;
  import result_pkg::*;

  logic   rd_valid;
  logic   rd_ready;
  entry_t rd_data;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );

endinterface

// File: rtl/hist_fifo.sv
// Synchronous DEPTH x entry_t FIFO with flush.
// Occupancy is tracked apart from the pointers.
module hist_fifo
  import result_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 din,
  output entry_t                 dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop frees the slot the push lands in when full.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clear && wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/result_history.sv
// Change logger for the dice/traffic mux result.
// Overflow drops and counts entries; upstream never stalls.
module result_history
  import result_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel,
  input  logic [2:0]             result,
  input  logic                   clear,
  result_history_if.master       rd,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);

  entry_t smp;
  entry_t prev;
  logic   prev_vld;
  logic   push;
  logic   pop;
  logic   drop;
  logic   full;
  logic   empty;
  entry_t head;

  assign smp.sel = sel;
  assign smp.val = result;

  assign push = !prev_vld || (smp != prev);
  assign pop  = !empty && rd.rd_ready;
  assign drop = push && full && !pop;

  assign rd.rd_valid = !empty;
  assign rd.rd_data  = head;

  hist_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (smp),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= '0;
      prev_vld <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      prev_vld <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      prev     <= smp;
      prev_vld <= 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule
